// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, looks up a direct-mapped one-word-line
// I-cache and fills misses over a req/done handshake with the memory controller.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          INDEX_BITS = 6,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_in,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state, state_n;
  logic [31:0]           pc, pc_n;
  logic                  discard, discard_n;
  logic [31:0]           if_pc_n, if_inst_n;
  logic                  if_valid_n;
  logic                  mem_req_n;
  logic [31:0]           mem_addr_n;
  logic [LINES-1:0]      valid, valid_n;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_BITS-1:0]   rd_tag, wr_tag;
  logic                  hit;
  logic                  cache_we;
  logic [31:0]           jump_target;

  assign rd_idx      = pc[INDEX_BITS+1:2];
  assign rd_tag      = pc[31:INDEX_BITS+2];
  assign wr_idx      = mem_addr[INDEX_BITS+1:2];
  assign wr_tag      = mem_addr[31:INDEX_BITS+2];
  assign hit         = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign jump_target = jump_addr & ~32'h3;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    discard_n  = discard;
    if_pc_n    = if_pc;
    if_inst_n  = if_inst;
    if_valid_n = if_valid;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    cache_we   = 1'b0;

    case (state)
      IDLE: begin
        if (jump_en) begin
          pc_n       = jump_target;
          if_pc_n    = jump_target;
          if_inst_n  = NOP_INST;
          if_valid_n = 1'b0;
        end else if (stall_in) begin
          // hold everything
        end else if (hit) begin
          if_pc_n    = pc;
          if_inst_n  = data_mem[rd_idx];
          if_valid_n = 1'b1;
          pc_n       = pc + 32'd4;
        end else begin
          mem_req_n  = 1'b1;
          mem_addr_n = pc;
          if_pc_n    = pc;
          if_inst_n  = NOP_INST;
          if_valid_n = 1'b0;
          state_n    = WAIT;
        end
      end

      WAIT: begin
        if (mem_done) begin
          // The fill always lands in the cache, even when the word is not presented.
          mem_req_n = 1'b0;
          cache_we  = 1'b1;
          state_n   = IDLE;
          discard_n = 1'b0;
          if (jump_en) begin
            pc_n       = jump_target;
            if_pc_n    = jump_target;
            if_inst_n  = NOP_INST;
            if_valid_n = 1'b0;
          end else if (stall_in) begin
            // pc still points at the filled line, so it hits once the stall clears
          end else if (discard) begin
            if_pc_n    = pc;
            if_inst_n  = NOP_INST;
            if_valid_n = 1'b0;
          end else begin
            if_pc_n    = mem_addr;
            if_inst_n  = mem_data;
            if_valid_n = 1'b1;
            pc_n       = pc + 32'd4;
          end
        end else begin
          if (jump_en) begin
            pc_n       = jump_target;
            discard_n  = 1'b1;
            if_pc_n    = jump_target;
            if_inst_n  = NOP_INST;
            if_valid_n = 1'b0;
          end else if (!stall_in) begin
            if_pc_n    = pc;
            if_inst_n  = NOP_INST;
            if_valid_n = 1'b0;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    valid_n = valid;
    if (cache_we) valid_n[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
      if_valid <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      valid    <= '0;
    end else if (rdy) begin
      state    <= state_n;
      pc       <= pc_n;
      discard  <= discard_n;
      if_pc    <= if_pc_n;
      if_inst  <= if_inst_n;
      if_valid <= if_valid_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
      valid    <= valid_n;
    end
  end

  // Tag/data storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && rdy && cache_we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: the bench plays the memory controller and
// checks the presented pc/inst/valid and request signals after every edge.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I4  = 32'h0010_0113;
  localparam logic [31:0] I8  = 32'h0020_0193;
  localparam logic [31:0] IA  = 32'h00a0_0513;
  localparam logic [31:0] I40 = 32'h0000_0517;
  localparam logic [31:0] I14 = 32'h0140_0593;
  localparam logic [31:0] I80 = 32'h0800_0613;
  localparam logic [31:0] I100 = 32'h0070_0713;
  localparam logic [31:0] IFC = 32'h0030_0793;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        stall_in = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int n_assert = 0;
  int n_fail   = 0;

  inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .stall_in  (stall_in),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_done  (mem_done),
    .mem_data  (mem_data),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_valid  (if_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                      input logic v, input logic req);
    chk({tag, ".if_pc"},    if_pc, pc);
    chk({tag, ".if_inst"},  if_inst, inst);
    chk({tag, ".if_valid"}, {31'h0, if_valid}, {31'h0, v});
    chk({tag, ".mem_req"},  {31'h0, mem_req}, {31'h0, req});
  endtask

  task automatic jump(input logic [31:0] a);
    jump_en = 1'b1; jump_addr = a;
    tick();
    jump_en = 1'b0;
  endtask

  task automatic done(input logic [31:0] d);
    mem_done = 1'b1; mem_data = d;
    tick();
    mem_done = 1'b0;
  endtask

  initial begin
    tick(); tick();
    outs("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("reset.mem_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // cold start
    tick(); outs("cold_miss", 32'h0, NOP, 1'b0, 1'b1);
    chk("cold_miss.addr", mem_addr, 32'h0);
    tick(); outs("cold_wait1", 32'h0, NOP, 1'b0, 1'b1);
    tick(); outs("cold_wait2", 32'h0, NOP, 1'b0, 1'b1);
    done(I0); outs("cold_emit", 32'h0, I0, 1'b1, 1'b0);
    tick(); outs("miss4", 32'h4, NOP, 1'b0, 1'b1);
    chk("miss4.addr", mem_addr, 32'h4);
    done(I4); outs("emit4", 32'h4, I4, 1'b1, 1'b0);
    tick(); chk("miss8.addr", mem_addr, 32'h8);
    chk("miss8.req", {31'h0, mem_req}, 32'h1);
    done(I8); outs("emit8", 32'h8, I8, 1'b1, 1'b0);

    // hit stream
    jump(32'h0); outs("jump0", 32'h0, NOP, 1'b0, 1'b0);
    tick(); outs("hit0", 32'h0, I0, 1'b1, 1'b0);
    tick(); outs("hit4", 32'h4, I4, 1'b1, 1'b0);
    tick(); outs("hit8", 32'h8, I8, 1'b1, 1'b0);

    // stall while presenting pc=4
    jump(32'h4); outs("jump4", 32'h4, NOP, 1'b0, 1'b0);
    tick(); outs("hit4b", 32'h4, I4, 1'b1, 1'b0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); outs("stall_hold", 32'h4, I4, 1'b1, 1'b0);
    end
    stall_in = 1'b0;
    tick(); outs("stall_release", 32'h8, I8, 1'b1, 1'b0);

    // jump during WAIT, misaligned target
    jump(32'h10); outs("jump10", 32'h10, NOP, 1'b0, 1'b0);
    tick(); outs("miss10", 32'h10, NOP, 1'b0, 1'b1);
    chk("miss10.addr", mem_addr, 32'h10);
    jump(32'h43); outs("wait_jump", 32'h40, NOP, 1'b0, 1'b1);
    chk("wait_jump.addr", mem_addr, 32'h10);
    tick(); outs("wait_after_jump", 32'h40, NOP, 1'b0, 1'b1);
    done(IA); outs("discarded", 32'h40, NOP, 1'b0, 1'b0);
    tick(); outs("miss40", 32'h40, NOP, 1'b0, 1'b1);
    chk("miss40.addr", mem_addr, 32'h40);
    done(I40); outs("emit40", 32'h40, I40, 1'b1, 1'b0);
    jump(32'h10); outs("jump10b", 32'h10, NOP, 1'b0, 1'b0);
    tick(); outs("hit10_cached", 32'h10, IA, 1'b1, 1'b0);

    // jump + stall + done together
    tick(); outs("miss14", 32'h14, NOP, 1'b0, 1'b1);
    chk("miss14.addr", mem_addr, 32'h14);
    jump_en = 1'b1; jump_addr = 32'h80; stall_in = 1'b1; mem_done = 1'b1; mem_data = I14;
    tick();
    jump_en = 1'b0; stall_in = 1'b0; mem_done = 1'b0;
    outs("collision", 32'h80, NOP, 1'b0, 1'b0);
    tick(); outs("miss80", 32'h80, NOP, 1'b0, 1'b1);
    chk("miss80.addr", mem_addr, 32'h80);
    done(I80); outs("emit80", 32'h80, I80, 1'b1, 1'b0);
    jump(32'h14); outs("jump14", 32'h14, NOP, 1'b0, 1'b0);
    tick(); outs("hit14_cached", 32'h14, I14, 1'b1, 1'b0);

    // conflict eviction at index 0
    jump(32'h100); outs("jump100", 32'h100, NOP, 1'b0, 1'b0);
    tick(); chk("miss100.addr", mem_addr, 32'h100);
    chk("miss100.req", {31'h0, mem_req}, 32'h1);
    done(I100); outs("emit100", 32'h100, I100, 1'b1, 1'b0);
    jump(32'h0); outs("jump0b", 32'h0, NOP, 1'b0, 1'b0);
    tick(); outs("evicted_miss0", 32'h0, NOP, 1'b0, 1'b1);
    chk("evicted_miss0.addr", mem_addr, 32'h0);

    // rdy freeze mid-WAIT, with other inputs wiggling
    rdy = 1'b0; jump_en = 1'b1; jump_addr = 32'h200; stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); outs("freeze", 32'h0, NOP, 1'b0, 1'b1);
      chk("freeze.addr", mem_addr, 32'h0);
    end
    rdy = 1'b1; jump_en = 1'b0; stall_in = 1'b0;
    done(I0); outs("thaw_emit0", 32'h0, I0, 1'b1, 1'b0);

    // PC wrap
    jump(32'hffff_fffc); outs("jump_top", 32'hffff_fffc, NOP, 1'b0, 1'b0);
    tick(); chk("miss_top.addr", mem_addr, 32'hffff_fffc);
    done(IFC); outs("emit_top", 32'hffff_fffc, IFC, 1'b1, 1'b0);
    tick(); outs("wrap_hit0", 32'h0, I0, 1'b1, 1'b0);

    // reset aborts an outstanding request
    jump(32'h200); outs("jump200", 32'h200, NOP, 1'b0, 1'b0);
    tick(); outs("miss200", 32'h200, NOP, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    outs("reset_abort", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("reset_abort.addr", mem_addr, 32'h0);
    tick(); outs("reset_cold_miss", 32'h0, NOP, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage of the 5-stage RV32I pipeline. It owns the PC, looks up a small direct-mapped instruction cache, and on a miss fetches a 32-bit word through a req/done handshake with the memory controller. It produces the pc/inst pair that the IF/ID pipeline register latches every cycle, with support for stall from hazard control and redirect from EX.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
INDEX_BITS, 6, cache index width; the cache holds 2^INDEX_BITS one-word lines
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) driven when no valid fetch is presented

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
rdy  in  1  global ready; when low, all state is frozen
stall_in  in  1  downstream stall; hold PC and outputs
jump_en  in  1  redirect request from EX, single-cycle pulse
jump_addr  in  32  redirect target
mem_req  out  1  fetch request to memory controller
mem_addr  out  32  word address of the request
mem_done  in  1  one-cycle pulse; mem_data is valid in the same cycle
mem_data  in  32  fetched instruction word
if_pc  out  32  PC of the presented instruction
if_inst  out  32  presented instruction, or NOP_INST for a bubble
if_valid  out  1  1 = if_inst is a real fetched instruction

Behaviour:
- Reset (rst=1 at a clock edge): pc<=RESET_PC; if_pc<=0; if_inst<=0; if_valid<=0; mem_req<=0; mem_addr<=0; state<=IDLE; discard<=0; all cache valid bits cleared. Reset overrides rdy and every other input and aborts any outstanding request. The memory controller is reset by the same rst.
- rdy=0: no register changes. The memory controller is also gated by rdy, so mem_done is never asserted while rdy=0.
- Cache addressing: index=pc[INDEX_BITS+1:2]; tag=pc[31:INDEX_BITS+2]. A hit requires valid[index]=1 and a tag match. The lookup is combinational; outputs are registered.
- PC is always word aligned: jump_addr[1:0] is ignored and forced to 0.
- States are IDLE and WAIT.
- Event priority, each cycle with rdy=1:
  - jump_en is highest.
  - Then stall_in.
  - Then the hit/miss handling below.
- IDLE:
  - jump_en: pc<=jump_addr; emit bubble (if_valid<=0, if_inst<=NOP_INST, if_pc<=jump_addr); no request issued.
  - else stall_in: hold pc and all if_* outputs unchanged.
  - else hit: if_pc<=pc; if_inst<=cache data; if_valid<=1; pc<=pc+4. Back-to-back hits give one instruction per cycle.
  - else miss: mem_req<=1; mem_addr<=pc; emit bubble (if_pc<=pc); state<=WAIT.
- WAIT:
  - mem_req stays 1 and mem_addr stays stable until mem_done.
  - Each cycle without mem_done: emit a bubble, unless stall_in=1, in which case outputs hold.
  - jump_en in WAIT: pc<=jump_addr; discard<=1; emit bubble; the request continues. The outstanding request cannot be aborted.
  - mem_done: mem_req<=0; write mem_data into the cache at mem_addr (set valid, write tag and data); state<=IDLE.
    - If discard=0, jump_en=0 and stall_in=0: emit if_pc<=mem_addr, if_inst<=mem_data, if_valid<=1; pc<=pc+4.
    - If stalled: hold outputs and pc; the next IDLE cycle after the stall clears then hits.
    - If discarded or jump_en in the same cycle: no emit; discard<=0; a jump in that cycle still loads pc<=jump_addr.
- Miss latency: the bubble appears on the cycle after the miss is detected; the instruction is presented on the edge following mem_done.
- PC wrap: pc+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- A cache write and a lookup at the same index in the same cycle: the lookup sees the old contents.

Test Plan:
- Reset then cold start: rst for 2 cycles, memory returns 0x00500093 at addr 0 after 3 cycles -> mem_req=1/mem_addr=0 one cycle after reset release; bubbles (if_valid=0, if_inst=0x00000013) until done; then if_pc=0, if_inst=0x00500093, if_valid=1; next request has mem_addr=4.
- Cache hit stream: preload 0,4,8 by misses, jump to 0 -> three consecutive cycles with if_pc=0,4,8, if_valid=1, mem_req=0 throughout.
- Stall: assert stall_in for 3 cycles while presenting pc=4 -> if_pc/if_inst/if_valid unchanged for 3 cycles; pc=8 presented the cycle after release.
- Jump during WAIT: miss at 0x10, jump_en with jump_addr=0x40 before mem_done -> data for 0x10 not presented (if_valid stays 0); the cache line for 0x10 becomes valid; next request has mem_addr=0x40.
- Jump vs stall/done collision: jump_en, stall_in and mem_done in the same cycle -> pc=jump_addr; bubble emitted; the returned word is cached but not presented.
- Conflict eviction and rdy freeze: fetch 0x000, then 0x100 (same index, INDEX_BITS=6), then jump to 0x000 -> miss, with a request to 0x000. With rdy=0 for 5 cycles mid-WAIT -> all outputs frozen.
